// File: rtl/exponent_arbiter_if.sv
// Bundle of requester, exponent-unit and response signals around exponent_arbiter.
// master = requesters plus exponent unit (environment side); slave = the arbiter.
interface exponent_arbiter_if #(
   parameter int BITS         = 32,
   parameter int NUM_REQ      = 4,
   parameter int MAX_INFLIGHT = 8
);
   localparam int CNT_W = $clog2(MAX_INFLIGHT) + 1;

   // Handshake: requester k transfers in a cycle where req_valid[k] & req_ready[k]
   // are both high at the clock edge. Once asserted, req_valid and req_data must stay
   // steady until that transfer happens. The exponent side and rsp_valid are pure
   // strobes with no backpressure, so every asserted cycle is one word.
   logic [NUM_REQ-1:0]      req_valid;
   logic [NUM_REQ*BITS-1:0] req_data;
   logic [NUM_REQ-1:0]      req_ready;
   logic                    exp_in_valid;
   logic [BITS-1:0]         exp_a;
   logic                    exp_out_valid;
   logic [BITS-1:0]         exp_c;
   logic [NUM_REQ-1:0]      rsp_valid;
   logic [BITS-1:0]         rsp_data;
   logic [CNT_W-1:0]        inflight;
   logic                    err;

   modport master (
      output req_valid, req_data, exp_out_valid, exp_c,
      input  req_ready, exp_in_valid, exp_a, rsp_valid, rsp_data, inflight, err
   );

   modport slave (
      input  req_valid, req_data, exp_out_valid, exp_c,
      output req_ready, exp_in_valid, exp_a, rsp_valid, rsp_data, inflight, err
   );
endinterface

// File: rtl/exponent_arbiter.sv
// Round-robin sharing of one fixed-latency exponent unit among NUM_REQ requesters.
// An in-order tag FIFO remembers who issued each operand so results are steered back.
module exponent_arbiter #(
   parameter int BITS         = 32,
   parameter     PRECISION    = "FIXED_16_16",
   parameter int NUM_REQ      = 4,
   parameter int MAX_INFLIGHT = 8
) (
   input logic               clk,
   input logic               rst,
   exponent_arbiter_if.slave bus
);
   localparam int TAG_W = $clog2(NUM_REQ);
   localparam int AW    = $clog2(MAX_INFLIGHT);
   localparam int CNT_W = AW + 1;

   // PRECISION only names the word format; words pass through untouched.
   if (NUM_REQ < 2 || NUM_REQ > 8 || $bits(PRECISION) == 0) begin : g_bad_config
   end

   logic [TAG_W-1:0] rr_ptr;
   logic [TAG_W-1:0] winner;
   logic             found;
   logic             transfer;
   logic [NUM_REQ-1:0] ready;
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [TAG_W-1:0] tag_mem [MAX_INFLIGHT];
   logic [TAG_W-1:0] pop_tag;
   logic             fifo_empty;
   logic             pop;
   logic [CNT_W-1:0] inflight_q;

   // First valid requester at or after rr_ptr, wrapping around.
   always_comb begin
      int idx;
      idx    = 0;
      winner = '0;
      found  = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = (int'(rr_ptr) + i) % NUM_REQ;
         if (!found && bus.req_valid[TAG_W'(idx)]) begin
            found  = 1'b1;
            winner = TAG_W'(idx);
         end
      end
   end

   // Full check uses the registered count only, so a same-cycle pop frees nothing.
   assign transfer = found && !rst && (inflight_q < CNT_W'(MAX_INFLIGHT));

   always_comb begin
      ready = '0;
      if (transfer) ready[winner] = 1'b1;
   end

   assign bus.req_ready = ready;
   assign bus.inflight  = inflight_q;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign pop        = bus.exp_out_valid && !fifo_empty;
   assign pop_tag    = tag_mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (transfer) tag_mem[wr_ptr[AW-1:0]] <= winner;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr           <= '0;
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         inflight_q       <= '0;
         bus.exp_in_valid <= 1'b0;
         bus.exp_a        <= '0;
         bus.rsp_valid    <= '0;
         bus.rsp_data     <= '0;
         bus.err          <= 1'b0;
      end else begin
         bus.exp_in_valid <= transfer;
         bus.rsp_valid    <= '0;
         if (transfer) begin
            bus.exp_a <= bus.req_data[int'(winner)*BITS +: BITS];
            wr_ptr    <= wr_ptr + 1'b1;
            rr_ptr    <= (winner == TAG_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
         end
         if (pop) begin
            rd_ptr                 <= rd_ptr + 1'b1;
            bus.rsp_valid[pop_tag] <= 1'b1;
            bus.rsp_data           <= bus.exp_c;
         end
         // A result with no matching tag is dropped and flagged until reset.
         if (bus.exp_out_valid && fifo_empty) bus.err <= 1'b1;
         case ({transfer, pop})
            2'b10:   inflight_q <= inflight_q + 1'b1;
            2'b01:   inflight_q <= inflight_q - 1'b1;
            default: inflight_q <= inflight_q;
         endcase
      end
   end
endmodule
